wb_mux_n_guarded: RTL

- Parametrised N-slave Wishbone classic interconnect. It succeeds the fixed three-slave mux between the rv_core CPU master and its CCM, GPIO and shared-bus slaves.
- Adds a registered slave decode that is held for the whole transaction.
- Adds an error response for unmapped addresses and a per-transaction timeout watchdog that aborts hung slaves.
- Captures sticky error status and the faulting address for firmware and debug.

---
 rtl/wb_ic_pkg.sv | 24 ++
 rtl/wb_mux_n_guarded_if.sv | 32 +++
 rtl/wb_addr_decode.sv | 41 ++++
 rtl/wb_mux_n_guarded.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
// Shared definitions for the guarded Wishbone interconnect.
//   state_e       : FSM encoding (IDLE / ACTIVE / ERR)
//   ERR_UNMAPPED  : err_status bit for accesses that hit no slave
//   ERR_TIMEOUT   : err_status bit for slaves aborted by the watchdog
//   DEFAULT_MASK  : default per-slave address mask (64 KiB windows)
//   width_min1()  : $clog2 that never returns 0, for index/counter widths
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_e;

  localparam int ERR_UNMAPPED = 0;
  localparam int ERR_TIMEOUT  = 1;

  localparam logic [31:0] DEFAULT_MASK = 32'hffff_0000;

  function automatic int width_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_mux_n_guarded_if.sv
// Master-side Wishbone classic bus between the CPU and the interconnect.
//   adr/dat_w/sel/we/cyc/stb : request from the master
//   dat_r/ack/err            : response from the interconnect
// modport master : the CPU (or bench) side
// modport slave  : the interconnect side
interface wb_mux_n_guarded_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  we;
  logic                  cyc;
  logic                  stb;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address decoder with priority resolution.
//   adr_i  : address to decode
//   base_i : packed slave base addresses, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   mask_i : packed slave masks, same packing
//   hit_o  : at least one slave matches
//   idx_o  : index of the lowest-numbered matching slave (0 when no hit)
module wb_addr_decode
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = width_min1(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0]            adr_i,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base_i,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] mask_i,
  output logic                             hit_o,
  output logic [IDX_W-1:0]                 idx_o
);

  logic [NUM_SLAVES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = ((adr_i & mask_i[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
                          (base_i[gi*ADDR_WIDTH +: ADDR_WIDTH] &
                           mask_i[gi*ADDR_WIDTH +: ADDR_WIDTH]));
    end
  endgenerate

  assign hit_o = |match;

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_mux_n_guarded.sv
// N-slave Wishbone classic interconnect with registered decode, unmapped-address
// error response, per-transaction timeout watchdog and sticky error capture.
//   wb_clk_i / wb_rst_i     : clock, asynchronous active-high reset
//   wbm                     : master bus (slave modport of wb_mux_n_guarded_if)
//   wbs_adr/dat/sel/we_o    : request broadcast to every slave lane
//   wbs_cyc_o / wbs_stb_o   : one-hot cycle/strobe to the selected slave
//   wbs_dat/ack/err_i       : per-lane slave responses
//   err_status_o            : sticky flags [0] unmapped, [1] timeout
//   err_addr_o              : address of the most recent error
//   err_clr_i               : clears err_status_o (a same-cycle set wins)
module wb_mux_n_guarded
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{DEFAULT_MASK}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  wb_mux_n_guarded_if.slave                wbm,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  output logic [NUM_SLAVES*SEL_WIDTH-1:0]  wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  output logic [1:0]                       err_status_o,
  output logic [ADDR_WIDTH-1:0]            err_addr_o,
  input  logic                             err_clr_i
);

  localparam int IDX_W = width_min1(NUM_SLAVES);
  localparam int CNT_W = width_min1(TIMEOUT_CYCLES + 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              status_q, status_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   lane_sel;     // one-hot decode of idx_q
  logic [NUM_SLAVES-1:0]   lane_en;      // lanes allowed to see cyc/stb this cycle
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic                    sel_ack;
  logic                    sel_err;
  logic                    timeout_fire;
  logic                    ack_o, err_o;
  logic [DATA_WIDTH-1:0]   dat_o;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_decode (
    .adr_i  (wbm.adr),
    .base_i (SLAVE_ADDR),
    .mask_i (SLAVE_MASK),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // Request fan-out and one-hot lane select.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_lane
      assign wbs_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = wbm.adr;
      assign wbs_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = wbm.dat_w;
      assign wbs_sel_o[gi*SEL_WIDTH +: SEL_WIDTH]   = wbm.sel;
      assign wbs_we_o[gi]                           = wbm.we;
      assign lane_sel[gi]                           = (idx_q == IDX_W'(gi));
      assign wbs_cyc_o[gi]                          = lane_en[gi] & wbm.cyc;
      assign wbs_stb_o[gi]                          = lane_en[gi] & wbm.stb;
    end
  endgenerate

  // Response mux from the latched slave (AND-OR so no out-of-range index).
  always_comb begin
    sel_dat = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (lane_sel[i]) begin
        sel_dat = sel_dat | wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ack = sel_ack | wbs_ack_i[i];
        sel_err = sel_err | wbs_err_i[i];
      end
    end
  end

  // The counter holds the number of completed ACTIVE cycles without a
  // response, so the watchdog fires on the first cycle after TIMEOUT_CYCLES
  // full strobed cycles.
  assign timeout_fire = (TIMEOUT_CYCLES != 0) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    status_d   = err_clr_i ? 2'b00 : status_q;
    err_addr_d = err_addr_q;
    lane_en    = '0;
    ack_o      = 1'b0;
    err_o      = 1'b0;
    dat_o      = '0;

    case (state_q)
      IDLE: begin
        if (wbm.cyc && wbm.stb) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            err_addr_d             = wbm.adr;
            status_d[ERR_UNMAPPED] = 1'b1;
            state_d                = ERR;
          end
        end
      end

      ACTIVE: begin
        ack_o   = sel_ack;
        err_o   = sel_err;
        dat_o   = sel_dat;
        lane_en = timeout_fire ? '0 : lane_sel;
        if (!wbm.cyc) begin
          state_d = IDLE;
        end else if (sel_ack || sel_err) begin
          // A response on the watchdog cycle still completes normally.
          state_d = IDLE;
        end else if (timeout_fire) begin
          err_addr_d            = wbm.adr;
          status_d[ERR_TIMEOUT] = 1'b1;
          state_d               = ERR;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ERR: begin
        err_o   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      status_q   <= 2'b00;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wbm.ack      = ack_o;
  assign wbm.err      = err_o;
  assign wbm.dat_r    = dat_o;
  assign err_status_o = status_q;
  assign err_addr_o   = err_addr_q;

endmodule
